// File: rtl/bidir_pkg.sv
// Shared constants and types for the bidirectional bus controller.
//   DATA_W  : bus and host data width
//   CNT_W   : width of the wait/turnaround counter
//   state_e : controller FSM states
package bidir_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2,
    WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_wait_cnt.sv
// Down-counter used for both the write turnaround and the read wait.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one, saturating at zero
//   zero_c   : combinational flag, counter is zero
module bus_wait_cnt
  import bidir_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement without wrapping below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Host-side controller for an 8-bit bidirectional bus buffer.
//   clk, rst           : clock, synchronous active-high reset
//   req, we, wdata     : host request, write/read select, write data
//   ready              : controller idle and able to accept a request
//   rdata, rvalid      : read data and its one-cycle completion pulse
//   bus_oe, bus_dout   : buffer enable and drive data
//   bus_din            : resolved bus value from the buffer
//   bus_strobe, bus_rnw: transaction strobe and read/not-write to the peer
module bidir_bus_ctrl
  import bidir_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned READ_WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din,
  output logic              bus_strobe,
  output logic              bus_rnw
);

  // Counter preload values: a counter at zero means "last cycle of the phase".
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_WAIT - 1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0] bus_dout_q, bus_dout_d;
  logic              bus_strobe_q, bus_strobe_d;
  logic              bus_rnw_q, bus_rnw_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_zero_c;

  bus_wait_cnt u_wait_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .zero_c  (cnt_zero_c)
  );

  // Next state and next registered outputs; outputs follow the next state
  // so they are valid in the cycle the FSM enters that state.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    bus_dout_d   = bus_dout_q;
    bus_strobe_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          bus_strobe_d = 1'b1;
          if (we) begin
            state_d    = DRIVE;
            bus_dout_d = wdata;
          end else begin
            state_d  = WAIT;
            cnt_load = 1'b1;
            cnt_val  = READ_LOAD;
          end
        end
      end
      DRIVE: begin
        state_d  = TURN;
        cnt_load = 1'b1;
        cnt_val  = TURN_LOAD;
      end
      TURN: begin
        if (cnt_zero_c) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          state_d  = IDLE;
          rdata_d  = bus_din;
          rvalid_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d   = (state_d == IDLE);
    bus_oe_d  = (state_d == DRIVE);
    bus_rnw_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      bus_oe_q     <= 1'b0;
      bus_dout_q   <= '0;
      bus_strobe_q <= 1'b0;
      bus_rnw_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      bus_oe_q     <= bus_oe_d;
      bus_dout_q   <= bus_dout_d;
      bus_strobe_q <= bus_strobe_d;
      bus_rnw_q    <= bus_rnw_d;
    end
  end

  assign ready      = ready_q;
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign bus_oe     = bus_oe_q;
  assign bus_dout   = bus_dout_q;
  assign bus_strobe = bus_strobe_q;
  assign bus_rnw    = bus_rnw_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Testbench for bidir_bus_ctrl: a cycle table against a default-parameter
// instance, plus latency sequences against a TURN_CYCLES=3/READ_WAIT=4 instance.
module tb_bidir_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst, req, we;
  logic [7:0] wdata, bus_din;
  logic       ready, rvalid, bus_oe, bus_strobe, bus_rnw;
  logic [7:0] rdata, bus_dout;

  bidir_bus_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .bus_oe(bus_oe), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_strobe(bus_strobe), .bus_rnw(bus_rnw)
  );

  // Slow instance
  logic       rst2, req2, we2;
  logic [7:0] wdata2, bus_din2;
  logic       ready2, rvalid2, bus_oe2, bus_strobe2, bus_rnw2;
  logic [7:0] rdata2, bus_dout2;

  bidir_bus_ctrl #(.TURN_CYCLES(3), .READ_WAIT(4)) dut2 (
    .clk(clk), .rst(rst2), .req(req2), .we(we2), .wdata(wdata2),
    .ready(ready2), .rdata(rdata2), .rvalid(rvalid2),
    .bus_oe(bus_oe2), .bus_dout(bus_dout2), .bus_din(bus_din2),
    .bus_strobe(bus_strobe2), .bus_rnw(bus_rnw2)
  );

  typedef struct {
    logic       rst, req, we;
    logic [7:0] wdata, din;
    logic       ready, rvalid;
    logic [7:0] rdata;
    logic       oe;
    logic [7:0] dout;
    logic       strobe, rnw;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic q, input logic w, input logic [7:0] wd,
                              input logic [7:0] di, input logic rdy, input logic rv, input logic [7:0] rd,
                              input logic oe, input logic [7:0] dout, input logic st, input logic rnw);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.wdata = wd; v.din = di;
    v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.oe = oe; v.dout = dout; v.strobe = st; v.rnw = rnw;
    return v;
  endfunction

  initial begin
    int busy, oe_cnt, lat;

    // Row inputs are sampled at one edge; expectations are the outputs in the cycle after it.
    //               rst req we wdata  din  | rdy rv rdata oe dout  st rnw
    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00,   1, 0, 8'h00, 0, 8'h00, 0, 0); // reset
    vecs[1]  = mk(0, 1, 1, 8'hA5, 8'h00,   0, 0, 8'h00, 1, 8'hA5, 1, 0); // write A5: DRIVE
    vecs[2]  = mk(0, 0, 0, 8'h00, 8'h00,   0, 0, 8'h00, 0, 8'hA5, 0, 0); // TURN
    vecs[3]  = mk(0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h00, 0, 8'hA5, 0, 0); // IDLE
    vecs[4]  = mk(0, 1, 0, 8'h00, 8'h3C,   0, 0, 8'h00, 0, 8'hA5, 1, 1); // read: WAIT1
    vecs[5]  = mk(0, 0, 0, 8'h00, 8'h3C,   0, 0, 8'h00, 0, 8'hA5, 0, 1); // WAIT2
    vecs[6]  = mk(0, 0, 0, 8'h00, 8'h3C,   1, 1, 8'h3C, 0, 8'hA5, 0, 0); // rvalid
    vecs[7]  = mk(0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h3C, 0, 8'hA5, 0, 0); // rdata holds
    vecs[8]  = mk(0, 1, 1, 8'h5A, 8'h00,   0, 0, 8'h3C, 1, 8'h5A, 1, 0); // write 5A
    vecs[9]  = mk(0, 1, 0, 8'h00, 8'h00,   0, 0, 8'h3C, 0, 8'h5A, 0, 0); // req in DRIVE ignored
    vecs[10] = mk(0, 1, 1, 8'hFF, 8'h00,   1, 0, 8'h3C, 0, 8'h5A, 0, 0); // req in TURN ignored
    vecs[11] = mk(0, 0, 0, 8'h00, 8'h00,   1, 0, 8'h3C, 0, 8'h5A, 0, 0); // no extra txn
    vecs[12] = mk(0, 1, 1, 8'h11, 8'h00,   0, 0, 8'h3C, 1, 8'h11, 1, 0); // held req: write 11
    vecs[13] = mk(0, 1, 0, 8'h00, 8'h00,   0, 0, 8'h3C, 0, 8'h11, 0, 0); // TURN
    vecs[14] = mk(0, 1, 0, 8'h00, 8'h22,   1, 0, 8'h3C, 0, 8'h11, 0, 0); // 1-cycle ready gap
    vecs[15] = mk(0, 1, 0, 8'h00, 8'h22,   0, 0, 8'h3C, 0, 8'h11, 1, 1); // read strobe
    vecs[16] = mk(0, 0, 0, 8'h00, 8'h22,   0, 0, 8'h3C, 0, 8'h11, 0, 1); // WAIT2
    vecs[17] = mk(0, 0, 0, 8'h00, 8'h22,   1, 1, 8'h22, 0, 8'h11, 0, 0); // rvalid 22
    vecs[18] = mk(0, 1, 0, 8'h00, 8'h77,   0, 0, 8'h22, 0, 8'h11, 1, 1); // read: WAIT1
    vecs[19] = mk(0, 0, 0, 8'h00, 8'h77,   0, 0, 8'h22, 0, 8'h11, 0, 1); // WAIT2
    vecs[20] = mk(1, 1, 0, 8'h00, 8'h77,   1, 0, 8'h00, 0, 8'h00, 0, 0); // reset aborts, beats req
    vecs[21] = mk(0, 0, 0, 8'h00, 8'h77,   1, 0, 8'h00, 0, 8'h00, 0, 0); // no late rvalid

    rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; wdata2 = 8'h00; bus_din2 = 8'h00;

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; req = vecs[i].req; we = vecs[i].we;
      wdata = vecs[i].wdata; bus_din = vecs[i].din;
      @(posedge clk);
      #1;
      rst2 = 1'b0;
      chk("ready",      i, 8'(ready),      8'(vecs[i].ready));
      chk("rvalid",     i, 8'(rvalid),     8'(vecs[i].rvalid));
      chk("rdata",      i, rdata,          vecs[i].rdata);
      chk("bus_oe",     i, 8'(bus_oe),     8'(vecs[i].oe));
      chk("bus_dout",   i, bus_dout,       vecs[i].dout);
      chk("bus_strobe", i, 8'(bus_strobe), 8'(vecs[i].strobe));
      chk("bus_rnw",    i, 8'(bus_rnw),    8'(vecs[i].rnw));
    end

    // Slow instance: write busy time must be 1 + 3 cycles, bus_oe high only once.
    chk("slow_idle_ready", 100, 8'(ready2), 8'h01);
    req2 = 1'b1; we2 = 1'b1; wdata2 = 8'hC3;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    chk("slow_wr_dout", 101, bus_dout2, 8'hC3);
    busy = 0;
    oe_cnt = 0;
    while (ready2 !== 1'b1 && busy < 20) begin
      if (bus_oe2 === 1'b1) oe_cnt++;
      busy++;
      @(posedge clk);
      #1;
    end
    chk("slow_wr_busy", 102, 8'(busy), 8'd4);
    chk("slow_wr_oe_cycles", 103, 8'(oe_cnt), 8'd1);

    // Slow instance: read completes 5 cycles after the accepting edge.
    req2 = 1'b1; we2 = 1'b0; bus_din2 = 8'h9E;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    chk("slow_rd_strobe", 104, 8'(bus_strobe2), 8'h01);
    lat = 1;
    oe_cnt = 0;
    while (rvalid2 !== 1'b1 && lat < 20) begin
      if (bus_oe2 === 1'b1) oe_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("slow_rd_latency", 105, 8'(lat), 8'd5);
    chk("slow_rd_rdata", 106, rdata2, 8'h9E);
    chk("slow_rd_ready", 107, 8'(ready2), 8'h01);
    chk("slow_rd_oe", 108, 8'(oe_cnt), 8'd0);
    @(posedge clk);
    #1;
    chk("slow_rd_pulse", 109, 8'(rvalid2), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 1, SHALL set the bus-released cycles after each write; legal range 1..15.
REQ-002 Parameter READ_WAIT, default 2, SHALL set the cycles from read launch to bus sample; legal range 1..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req, input, 1 bit: host transaction request.
REQ-006 Port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 Port wdata, input, 8 bits: host write data.
REQ-008 Port ready, output, 1 bit: controller can accept a request.
REQ-009 Port rdata, output, 8 bits: read data, valid when rvalid=1.
REQ-010 Port rvalid, output, 1 bit: single-cycle read-complete pulse.
REQ-011 Port bus_oe, output, 1 bit: drives the enable input of the 8-bit bidirectional buffer.
REQ-012 Port bus_dout, output, 8 bits: drives the din input of the buffer.
REQ-013 Port bus_din, input, 8 bits: from the dout output of the buffer, i.e. the resolved bus value.
REQ-014 Port bus_strobe, output, 1 bit: one-cycle transaction strobe to the bus peer.
REQ-015 Port bus_rnw, output, 1 bit: 1 = current transaction is a read.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, TURN and WAIT; ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted at a rising edge where req=1 and ready=1; we and wdata SHALL be captured at that edge; req while ready=0 SHALL be ignored, not queued.
REQ-018 Write accepted at edge k: cycle k+1 in DRIVE with bus_oe=1, bus_dout=captured wdata, bus_strobe=1, bus_rnw=0.
REQ-019 After DRIVE: exactly TURN_CYCLES cycles in TURN with bus_oe=0 and bus_strobe=0, then IDLE; write busy time = 1+TURN_CYCLES cycles.
REQ-020 Read accepted at edge k: cycles k+1..k+READ_WAIT in WAIT with bus_oe=0 and bus_rnw=1; bus_strobe=1 only in the first WAIT cycle.
REQ-021 At the edge ending the last WAIT cycle, rdata SHALL load bus_din and the FSM SHALL enter IDLE; rvalid SHALL be 1 for exactly that next cycle, concurrent with ready=1.
REQ-022 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter rdata.
REQ-023 bus_oe SHALL be 1 only in DRIVE; it SHALL never be 1 in two consecutive cycles, and every 1 SHALL be followed by at least TURN_CYCLES cycles at 0.
REQ-024 Back-to-back: a request held asserted SHALL be accepted on the first edge in IDLE, giving a 1-cycle ready gap between transactions.
REQ-025 All outputs SHALL be registered; bus_dout SHALL hold its last driven value when bus_oe=0.
REQ-026 The wait counter SHALL be 4 bits, load the parameter value minus 1 on state entry, and decrement to 0 without wrap.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE; in the following cycle ready=1, rvalid=0, bus_oe=0, bus_strobe=0, bus_rnw=0, bus_dout=0, rdata=0.
REQ-028 Reset mid-transaction SHALL abort it with no rvalid pulse; rst SHALL override a simultaneous req.

Structure
REQ-029 Package bidir_pkg SHALL hold the DATA_W=8 constant and the state enum type.
REQ-030 The wait/turnaround counter SHALL be one sub-module, bus_wait_cnt (load, count-down, zero flag); the FSM stays in bidir_bus_ctrl.

Verification
REQ-031 Write 0xA5 with defaults, req pulsed at edge 0 -> bus_oe=1, bus_dout=0xA5, bus_strobe=1 in cycle 1; bus_oe=0 in cycle 2; ready=1 in cycle 3.
REQ-032 Read with defaults, bus_din=0x3C -> bus_strobe in cycle 1; rvalid=1, rdata=0x3C in cycle 3; bus_oe=0 throughout.
REQ-033 req held high, write 0x11, then read of 0x22 -> bus_oe high only in cycle 1; read strobe in cycle 4; rvalid in cycle 6, rdata=0x22.
REQ-034 TURN_CYCLES=3, READ_WAIT=4 -> write busy 4 cycles; read rvalid 5 cycles after accept.
REQ-035 rst asserted in the second WAIT cycle of a read -> no rvalid, all outputs at reset values the next cycle, ready=1.
REQ-036 req with ready=0 during TURN -> request ignored, no extra transaction, no strobe.
